// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, ALU op encodings, FSM state encoding and the
// operand-latch record used by the alu_seq command sequencer.
package alu_seq_pkg;

    localparam int DW   = 8;   // data width
    localparam int RW   = 2;   // register index width
    localparam int NREG = 4;   // register count

    // ALU op encodings driven on alu_op
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_ADD1   = 2'b01;
    localparam logic [1:0] OP_AND    = 2'b10;
    localparam logic [1:0] OP_GENBIT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Everything captured at command acceptance. Operands are read from the
    // register file at that point, so a later write to the same register
    // cannot change the command already in flight.
    typedef struct packed {
        logic [1:0]    op;
        logic [RW-1:0] dst;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } operand_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4x8 register file.
// Ports:
//   clk, reset        - clock, synchronous active-high clear of all entries
//   we, waddr, wdata  - synchronous write port
//   ra_addr / ra_data - combinational read port (A operand)
//   rb_addr / rb_data - combinational read port (B operand)
//   rd_addr / rd_data - combinational read port (debug)
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [RW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic [RW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [NREG];

    // Reset wins over a write in the same cycle, which is what discards an
    // in-flight command's write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: command sequencer in front of the 8-bit combinational micro ALU.
// Accepts one command per 3 cycles (IDLE -> EXEC -> WB), latches its
// operands, presents them to the ALU for the EXEC cycle and writes the ALU
// result back to the register file and the carry/zero flags.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE with reset low,
// and never depends on cmd_valid. The command fields are sampled only on
// that edge; cmd_valid is ignored at all other times.
//
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   cmd_valid / cmd_ready        - command handshake
//   cmd_op, cmd_dst, cmd_srca,
//   cmd_srcb, cmd_imm_sel, cmd_imm - command fields
//   alu_a, alu_b, alu_cin, alu_op - to the ALU (held from operand latch)
//   alu_result, alu_cout          - from the ALU
//   done, done_data               - write-back pulse and written value
//   carry, zero                   - status flags of last completed command
//   rd_addr / rd_data             - combinational debug register read
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [RW-1:0] cmd_dst,
    input  logic [RW-1:0] cmd_srca,
    input  logic [RW-1:0] cmd_srcb,
    input  logic          cmd_imm_sel,
    input  logic [DW-1:0] cmd_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_cin,
    output logic [1:0]    alu_op,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_cout,
    output logic          done,
    output logic [DW-1:0] done_data,
    output logic          carry,
    output logic          zero,
    input  logic [RW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    state_t        state;
    state_t        state_next;
    operand_t      opnd_q;
    logic          accept;
    logic          rf_we;
    logic [DW-1:0] rf_a;
    logic [DW-1:0] rf_b;

    alu_seq_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (opnd_q.dst),
        .wdata   (alu_result),
        .ra_addr (cmd_srca),
        .ra_data (rf_a),
        .rb_addr (cmd_srcb),
        .rb_data (rf_b),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rf_we      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = ~reset;
                if (cmd_valid && !reset) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // ALU output is written straight back at the end of EXEC;
                // there is no pipeline register between the ALU and the rf.
                rf_we      = 1'b1;
                state_next = S_WB;
            end
            S_WB: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign accept = cmd_valid & cmd_ready;

    // Operand latch, flags and write-back status
    always_ff @(posedge clk) begin
        if (reset) begin
            opnd_q    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
            done_data <= '0;
        end else begin
            done <= (state == S_EXEC);
            if (accept) begin
                opnd_q.op  <= cmd_op;
                opnd_q.dst <= cmd_dst;
                opnd_q.a   <= rf_a;
                opnd_q.b   <= cmd_imm_sel ? cmd_imm : rf_b;
            end
            if (state == S_EXEC) begin
                carry     <= alu_cout;
                zero      <= (alu_result == '0);
                done_data <= alu_result;
            end
        end
    end

    assign alu_a   = opnd_q.a;
    assign alu_b   = opnd_q.b;
    assign alu_op  = opnd_q.op;
    assign alu_cin = carry;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the micro ALU
// hooked to the alu_* ports.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_srca;
    logic [1:0] cmd_srcb;
    logic       cmd_imm_sel;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic       done;
    logic [7:0] done_data;
    logic       carry;
    logic       zero;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;

    int checks;
    int passes;

    alu_seq dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_dst     (cmd_dst),
        .cmd_srca    (cmd_srca),
        .cmd_srcb    (cmd_srcb),
        .cmd_imm_sel (cmd_imm_sel),
        .cmd_imm     (cmd_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .done        (done),
        .done_data   (done_data),
        .carry       (carry),
        .zero        (zero),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    logic [8:0] alu_full;
    always_comb begin
        alu_full = 9'h000;
        case (alu_op)
            OP_ADD:  alu_full = {1'b0, alu_a} + {1'b0, alu_b};
            OP_ADD1: alu_full = 9'h100 ^ ({1'b0, alu_a} + {1'b0, alu_b} + 9'd1);
            OP_AND:  alu_full = {1'b0, alu_a & alu_b};
            default: alu_full = {1'b0, (8'd1 << alu_b)};
        endcase
    end
    assign alu_result = alu_full[7:0];
    assign alu_cout   = alu_full[8];

    // ---------------- driver ----------------
    // Issues one command, waits for acceptance, then samples the EXEC cycle
    // (cin) and the WB cycle (done, done_data, flags).
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] dst,
                           input logic [1:0] srca, input logic [1:0] srcb,
                           input logic isel, input logic [7:0] imm,
                           output logic [7:0] d, output logic c,
                           output logic z, output logic dn, output logic cin);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_dst = dst; cmd_srca = srca; cmd_srcb = srcb;
        cmd_imm_sel = isel; cmd_imm = imm; cmd_valid = 1'b1;
        n = 0;
        #1;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        cin = alu_cin;
        @(negedge clk);
        #1;
        d = done_data; c = carry; z = zero; dn = done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
        checks++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b want 0", carry); else passes++;
        checks++; if (zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", zero); else passes++;
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00) $display("FAIL reset_operands: got a=%h b=%h want 00 00", alu_a, alu_b); else passes++;
        for (int i = 0; i < 4; i++) begin
            rd_addr = i[1:0];
            #1;
            checks++;
            if (rd_data !== 8'h00) $display("FAIL reset_rf%0d: got %h want 00", i, rd_data); else passes++;
        end
    endtask

    task automatic test_imm_chain();
        logic [7:0] d; logic c, z, dn, cin;
        run_cmd(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h16, d, c, z, dn, cin);
        checks++; if (dn !== 1'b1) $display("FAIL chain_add_done: got %b want 1", dn); else passes++;
        checks++; if (d !== 8'h16 || c !== 1'b0 || z !== 1'b0) $display("FAIL chain_add: got d=%h c=%b z=%b want 16 0 0", d, c, z); else passes++;
        run_cmd(OP_AND, 2'd2, 2'd1, 2'd0, 1'b1, 8'h0F, d, c, z, dn, cin);
        checks++; if (d !== 8'h06) $display("FAIL chain_and: got %h want 06", d); else passes++;
        rd_addr = 2'd2; #1;
        checks++; if (rd_data !== 8'h06) $display("FAIL chain_r2: got %h want 06", rd_data); else passes++;
        run_cmd(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h28, d, c, z, dn, cin);
        checks++; if (d !== 8'h28) $display("FAIL chain_load_r3: got %h want 28", d); else passes++;
        // dst == srca: old value of r3 is the A operand
        run_cmd(OP_AND, 2'd3, 2'd3, 2'd0, 1'b1, 8'hF7, d, c, z, dn, cin);
        checks++; if (d !== 8'h20) $display("FAIL chain_and_self: got %h want 20", d); else passes++;
        rd_addr = 2'd3; #1;
        checks++; if (rd_data !== 8'h20) $display("FAIL chain_r3: got %h want 20", rd_data); else passes++;
    endtask

    task automatic test_carry_zero();
        logic [7:0] d; logic c, z, dn, cin;
        run_cmd(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, d, c, z, dn, cin);
        checks++; if (d !== 8'hFF || c !== 1'b0) $display("FAIL cz_load: got d=%h c=%b want FF 0", d, c); else passes++;
        run_cmd(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, d, c, z, dn, cin);
        checks++; if (d !== 8'h00 || c !== 1'b1 || z !== 1'b1) $display("FAIL cz_wrap: got d=%h c=%b z=%b want 00 1 1", d, c, z); else passes++;
        run_cmd(OP_ADD1, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01, d, c, z, dn, cin);
        checks++; if (cin !== 1'b1) $display("FAIL cz_cin: got %b want 1", cin); else passes++;
        checks++; if (d !== 8'h02 || c !== 1'b1 || z !== 1'b0) $display("FAIL cz_add1: got d=%h c=%b z=%b want 02 1 0", d, c, z); else passes++;
    endtask

    task automatic test_genbit();
        logic [7:0] d; logic c, z, dn, cin;
        run_cmd(OP_GENBIT, 2'd0, 2'd0, 2'd0, 1'b1, 8'h03, d, c, z, dn, cin);
        checks++; if (d !== 8'h08 || c !== 1'b0) $display("FAIL genbit3: got d=%h c=%b want 08 0", d, c); else passes++;
        run_cmd(OP_GENBIT, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, d, c, z, dn, cin);
        checks++; if (d !== 8'h01 || c !== 1'b0) $display("FAIL genbit0: got d=%h c=%b want 01 0", d, c); else passes++;
        // register-register: r2 = r0 + r1 using the srcb path
        run_cmd(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'hAA, d, c, z, dn, cin);
        checks++; if (d !== 8'h09 || c !== 1'b0) $display("FAIL regreg_add: got d=%h c=%b want 09 0", d, c); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int acc_cyc [2];
        int nacc;
        int ndone_between;
        logic [7:0] e;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        nacc = 0; ndone_between = 0;
        exp_q.push_back(8'h18);
        exp_q.push_back(8'h19);
        @(negedge clk);
        cmd_op = OP_ADD; cmd_dst = 2'd3; cmd_srca = 2'd0; cmd_srcb = 2'd0;
        cmd_imm_sel = 1'b1; cmd_imm = 8'h10; cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (nacc >= 2) cmd_valid = 1'b0;
                else if (nacc == 1) begin cmd_srca = 2'd3; cmd_imm = 8'h01; end
            end
            #1;
            if (done) begin
                if (nacc == 1) ndone_between++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra_done: cycle %0d data=%h want no pulse", i, done_data);
                else begin
                    e = exp_q.pop_front();
                    if (done_data !== e) $display("FAIL b2b_data: got %h want %h", done_data, e); else passes++;
                end
            end
            if (cmd_valid && cmd_ready && nacc < 2) begin
                acc_cyc[nacc] = i;
                nacc++;
            end
        end
        cmd_valid = 1'b0;
        checks++; if (nacc !== 2) $display("FAIL b2b_accepts: got %0d want 2", nacc); else passes++;
        checks++; if (acc_cyc[1] - acc_cyc[0] !== 3) $display("FAIL b2b_spacing: got %0d want 3", acc_cyc[1] - acc_cyc[0]); else passes++;
        checks++; if (ndone_between !== 1) $display("FAIL b2b_done_width: got %0d want 1", ndone_between); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL b2b_missing_done: got %0d pending want 0", exp_q.size()); else passes++;
        rd_addr = 2'd3; #1;
        checks++; if (rd_data !== 8'h19) $display("FAIL b2b_r3: got %h want 19", rd_data); else passes++;
    endtask

    task automatic test_reset_mid_exec();
        logic [7:0] d; logic c, z, dn, cin;
        @(negedge clk);
        cmd_op = OP_ADD; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd0;
        cmd_imm_sel = 1'b1; cmd_imm = 8'h05; cmd_valid = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL mid_ready_before: got %b want 1", cmd_ready); else passes++;
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (alu_a !== 8'h08 || alu_b !== 8'h05) $display("FAIL mid_exec_operands: got a=%h b=%h want 08 05", alu_a, alu_b); else passes++;
        @(negedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b0 || done !== 1'b0) $display("FAIL mid_in_reset: got ready=%b done=%b want 0 0", cmd_ready, done); else passes++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL mid_ready_after: got %b want 1", cmd_ready); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL mid_no_done: got %b want 0", done); else passes++;
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 2'b00 || alu_cin !== 1'b0)
            $display("FAIL mid_operands_clr: got a=%h b=%h op=%b cin=%b want 00 00 00 0", alu_a, alu_b, alu_op, alu_cin); else passes++;
        rd_addr = 2'd2; #1;
        checks++; if (rd_data !== 8'h00) $display("FAIL mid_r2: got %h want 00", rd_data); else passes++;
        rd_addr = 2'd3; #1;
        checks++; if (rd_data !== 8'h00) $display("FAIL mid_r3: got %h want 00", rd_data); else passes++;
        // sequencer is usable straight after reset, with r0 cleared
        run_cmd(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h33, d, c, z, dn, cin);
        checks++; if (dn !== 1'b1 || d !== 8'h33) $display("FAIL mid_recover: got done=%b d=%h want 1 33", dn, d); else passes++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0; passes = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dst = 2'd0;
        cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_imm_sel = 1'b0; cmd_imm = 8'h00;
        rd_addr = 2'd0;
        test_reset();
        test_imm_chain();
        test_carry_zero();
        test_genbit();
        test_back_to_back();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
